// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg
// Shared types for the cpu6502 instruction trace buffer.
//   trace_state_t : capture state machine encoding (also driven on state_o)
//   trace_entry_t : one register snapshot, MSB to LSB {PC, A, X, Y, SR, SP}
//   ENTRY_BASE_W  : width of a snapshot without a timestamp
// Optional build macro: TRACE_TIMESTAMP_EN (see cpu_trace_buffer).
package cpu_trace_pkg;

    localparam int ENTRY_BASE_W = 56;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  a;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  sr;
        logic [7:0]  sp;
    } trace_entry_t;

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram
// Simple dual-port trace storage: one write port, one registered read port.
// Written as a plain array with a registered read so it maps onto block RAM.
// Ports:
//   clk, srst        : clock, synchronous active-high reset (read register only)
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request; data appears on rd_data next cycle
//   rd_data          : registered read data, holds while rd_en is low
module trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = ENTRY_BASE_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reads and writes never overlap in time (writes stop before readout
    // starts), so no read-during-write behaviour needs to be defined.
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
// On-chip instruction trace for the cpu6502 core. Each opcode-fetch strobe
// snapshots {PC, A, X, Y, SR, SP} into a circular buffer. A PC-match or forced
// trigger starts a post-trigger window; when it closes (or the buffer fills in
// stop-on-full mode) the entries drain oldest-first over a valid/ready port.
// Build macro: TRACE_TIMESTAMP_EN adds a free-running TS_W-bit cycle counter
// whose value is stored in the entry MSBs.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   arm                 : clear buffer and enter ARMED (wins over everything else)
//   force_trig          : immediate trigger while ARMED
//   trig_en, trig_pc    : PC-match trigger enable and value
//   stop_on_full        : 1 = stop when full, 0 = overwrite oldest
//   fetch, PC..SP       : capture strobe and CPU register snapshot
//   rd_data/valid/ready : readout stream, oldest entry first
//   state_o             : 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count               : entries held
//   overflow            : an entry was overwritten since the last arm
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int TS_W      = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_BITS  = TS_W,
`else
    // No timestamp field; TS_W is kept referenced so the parameter list is
    // identical in both builds.
    localparam int TS_BITS  = 0 * TS_W,
`endif
    localparam int ENTRY_W  = ENTRY_BASE_W + TS_BITS,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               arm,
    input  logic               force_trig,
    input  logic               trig_en,
    input  logic [15:0]        trig_pc,
    input  logic               stop_on_full,
    input  logic               fetch,
    input  logic [15:0]        PC,
    input  logic [7:0]         A,
    input  logic [7:0]         X,
    input  logic [7:0]         Y,
    input  logic [7:0]         SR,
    input  logic [7:0]         SP,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [1:0]         state_o,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    trace_state_t  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;

    logic               wr_en;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic               full;
    logic               take;
    trace_entry_t       entry;

    assign entry = '{pc: PC, a: A, x: X, y: Y, sr: SR, sp: SP};

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb ts_d = ts_q + 1'b1;

    // Free-running from reset; arm deliberately leaves it alone so stamps
    // stay comparable across captures.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wr_data = {ts_q, entry};
`else
    assign wr_data = entry;
`endif

    assign full = (count_q == DEPTH_C);
    assign take = rd_valid_q && rd_ready;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = rd_ptr_q;

        if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ARMED, POST: begin
                    if (fetch && full && stop_on_full) begin
                        state_d = DONE;
                    end else begin
                        if (fetch) begin
                            wr_en    = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            if (full) begin
                                overflow_d = 1'b1;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                        if (state_q == ARMED) begin
                            if (force_trig || (fetch && trig_en && (PC == trig_pc))) begin
                                post_cnt_d = POST_INIT;
                                state_d    = (POST_TRIG == 0) ? DONE : POST;
                            end
                        end else if (fetch) begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == AW'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
                    // Oldest entry after this cycle's capture; only consumed
                    // once the state lands in DONE. A full buffer gives
                    // count[AW-1:0]==0, i.e. the oldest entry sits at wr_ptr.
                    rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                end
                DONE: begin
                    // rd_ptr_q is the entry currently presented (or about to
                    // be). On a transfer, prefetch the next one so the stream
                    // has no bubble; otherwise the RAM output register holds.
                    count_d    = count_q - CW'(take);
                    rd_ptr_d   = rd_ptr_q + AW'(take);
                    rd_addr    = rd_ptr_d;
                    rd_valid_d = (count_d != '0);
                    rd_en      = (!rd_valid_q || take) && (count_d != '0);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (CLK),
        .srst    (RESET),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign state_o  = state_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer
// Directed table-driven bench for cpu_trace_buffer. Two instances share all
// inputs: dut_a (DEPTH=16, POST_TRIG=2) and dut_b (DEPTH=4, POST_TRIG=2);
// each vector names the instance whose outputs it checks.
module tb_cpu_trace_buffer;

`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 56 + 16;
`else
    localparam int EW = 56;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, arm = 1'b0, force_trig = 1'b0, trig_en = 1'b0;
    logic        stop_on_full = 1'b0, fetch = 1'b0, rd_ready = 1'b0;
    logic [15:0] trig_pc = 16'hC005, pc = 16'h0000;
    logic [7:0]  a, x, y, sr, sp;

    logic [EW-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, overflow_a, overflow_b;
    logic [1:0]    state_a, state_b;
    logic [4:0]    count_a;
    logic [2:0]    count_b;

    int errors = 0;
    int checks = 0;

    // Register values are a fixed function of PC so readout can check all
    // fields of an entry from the PC alone.
    function automatic logic [39:0] regs_of(input logic [15:0] p);
        return {p[7:0], p[15:8], p[7:0] ^ 8'h5A, p[15:8] ^ 8'hA5, ~p[7:0]};
    endfunction

    assign {a, x, y, sr, sp} = regs_of(pc);

    cpu_trace_buffer #(.DEPTH(16), .POST_TRIG(2), .TS_W(16)) dut_a (
        .CLK(clk), .RESET(rst), .arm(arm), .force_trig(force_trig),
        .trig_en(trig_en), .trig_pc(trig_pc), .stop_on_full(stop_on_full),
        .fetch(fetch), .PC(pc), .A(a), .X(x), .Y(y), .SR(sr), .SP(sp),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_ready(rd_ready),
        .state_o(state_a), .count(count_a), .overflow(overflow_a)
    );

    cpu_trace_buffer #(.DEPTH(4), .POST_TRIG(2), .TS_W(16)) dut_b (
        .CLK(clk), .RESET(rst), .arm(arm), .force_trig(force_trig),
        .trig_en(trig_en), .trig_pc(trig_pc), .stop_on_full(stop_on_full),
        .fetch(fetch), .PC(pc), .A(a), .X(x), .Y(y), .SR(sr), .SP(sp),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
        .state_o(state_b), .count(count_b), .overflow(overflow_b)
    );

    typedef struct {
        bit          rst, arm, frc, fet, rdy, ten, sof, use_b;
        logic [15:0] pc;
        logic [1:0]  e_state;
        int          e_count;
        bit          e_ovf, e_valid;
        logic [15:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    bit   cur_b, cur_ten, cur_sof;

    task automatic add(input bit r, ar, fr, fe, rd, input logic [15:0] p,
                       input logic [1:0] st, input int cnt, input bit ovf,
                       input bit vld, input logic [15:0] epc);
        vec_t v;
        v.rst = r; v.arm = ar; v.frc = fr; v.fet = fe; v.rdy = rd;
        v.ten = cur_ten; v.sof = cur_sof; v.use_b = cur_b; v.pc = p;
        v.e_state = st; v.e_count = cnt; v.e_ovf = ovf; v.e_valid = vld; v.e_pc = epc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit r, ar, fr, fe, rd, input logic [15:0] p);
        @(negedge clk);
        rst = r; arm = ar; force_trig = fr; fetch = fe; rd_ready = rd; pc = p;
        @(posedge clk);
        #1;
    endtask

    vec_t          v;
    logic [1:0]    got_st;
    int            got_cnt;
    logic          got_ovf, got_vld;
    logic [EW-1:0] got_data;

    initial begin
        // ---- test 1: PC-match trigger, POST_TRIG=2, dut_a ----
        cur_b = 0; cur_ten = 1; cur_sof = 0;
        add(1, 0, 0, 0, 0, 16'h0000, 2'd0, 0, 0, 0, 16'h0);
        add(0, 0, 1, 1, 0, 16'hC005, 2'd0, 0, 0, 0, 16'h0);   // IDLE ignores fetch/trigger
        add(0, 1, 0, 0, 0, 16'h0000, 2'd1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 1, 0, 16'hC000 + 16'(i), 2'd1, i + 1, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC005, 2'd2, 6, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC006, 2'd2, 7, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC007, 2'd3, 8, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC008, 2'd3, 8, 0, 1, 16'hC000);
        for (int k = 1; k < 8; k++)
            add(0, 0, 0, 1, 1, 16'hC008 + 16'(k), 2'd3, 8 - k, 0, 1, 16'hC000 + 16'(k));
        add(0, 0, 0, 0, 1, 16'h0000, 2'd3, 0, 0, 0, 16'h0);

        // ---- test 2: DEPTH=4 wrap with overflow, then forced trigger ----
        cur_b = 1; cur_ten = 0; cur_sof = 0;
        add(0, 1, 0, 0, 0, 16'h0000, 2'd1, 0, 0, 0, 16'h0);
        for (int i = 1; i <= 6; i++)
            add(0, 0, 0, 1, 0, 16'(i), 2'd1, (i > 4) ? 4 : i, i > 4, 0, 16'h0);
        add(0, 0, 1, 0, 0, 16'h0000, 2'd2, 4, 1, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'd7, 2'd2, 4, 1, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'd8, 2'd3, 4, 1, 0, 16'h0);
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 0, 1, 16'h0000, 2'd3, 4 - k, 1, 1, 16'd5 + 16'(k));
        add(0, 0, 0, 0, 1, 16'h0000, 2'd3, 0, 1, 0, 16'h0);

        // ---- tests 3+4: stop-on-full, stalled then streaming readout ----
        cur_b = 1; cur_ten = 0; cur_sof = 1;
        add(0, 1, 0, 0, 0, 16'h0000, 2'd1, 0, 0, 0, 16'h0);
        for (int i = 1; i <= 4; i++)
            add(0, 0, 0, 1, 0, 16'(i), 2'd1, i, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'd5, 2'd3, 4, 0, 0, 16'h0);
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 0, 0, 16'h0000, 2'd3, 4, 0, 1, 16'd1);
        for (int k = 1; k < 4; k++)
            add(0, 0, 0, 0, 1, 16'h0000, 2'd3, 4 - k, 0, 1, 16'd1 + 16'(k));
        add(0, 0, 0, 0, 1, 16'h0000, 2'd3, 0, 0, 0, 16'h0);

        // ---- test 5: arm with fetch mid-POST, trigger ignored in POST ----
        cur_b = 0; cur_ten = 1; cur_sof = 0;
        add(0, 1, 0, 0, 0, 16'h0000, 2'd1, 0, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC005, 2'd2, 1, 0, 0, 16'h0);
        add(0, 1, 0, 1, 0, 16'hC006, 2'd1, 0, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC001, 2'd1, 1, 0, 0, 16'h0);
        add(0, 0, 1, 1, 0, 16'hC002, 2'd2, 2, 0, 0, 16'h0);
        add(0, 0, 1, 1, 0, 16'hC003, 2'd2, 3, 0, 0, 16'h0);
        add(0, 0, 0, 1, 0, 16'hC004, 2'd3, 4, 0, 0, 16'h0);
        add(0, 0, 0, 0, 0, 16'h0000, 2'd3, 4, 0, 1, 16'hC001);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            rst = v.rst; arm = v.arm; force_trig = v.frc; fetch = v.fet;
            rd_ready = v.rdy; pc = v.pc; trig_en = v.ten; stop_on_full = v.sof;
            @(posedge clk);
            #1;
            if (v.use_b) begin
                got_st = state_b; got_cnt = int'(count_b); got_ovf = overflow_b;
                got_vld = rd_valid_b; got_data = rd_data_b;
            end else begin
                got_st = state_a; got_cnt = int'(count_a); got_ovf = overflow_a;
                got_vld = rd_valid_a; got_data = rd_data_a;
            end
            $display("vec %0d dut_%s st=%0d cnt=%0d ovf=%0b vld=%0b pc=%h",
                     i, v.use_b ? "b" : "a", got_st, got_cnt, got_ovf, got_vld, got_data[55:40]);
            chk($sformatf("v%0d.state", i), 64'(got_st), 64'(v.e_state));
            chk($sformatf("v%0d.count", i), 64'(got_cnt), 64'(v.e_count));
            chk($sformatf("v%0d.overflow", i), 64'(got_ovf), 64'(v.e_ovf));
            chk($sformatf("v%0d.rd_valid", i), 64'(got_vld), 64'(v.e_valid));
            if (v.e_valid) begin
                chk($sformatf("v%0d.pc", i), 64'(got_data[55:40]), 64'(v.e_pc));
                chk($sformatf("v%0d.regs", i), 64'(got_data[39:0]), 64'(regs_of(v.e_pc)));
            end
            if (v.rst) chk($sformatf("v%0d.rd_data_zero", i), 64'(got_data == '0), 64'd1);
        end

        // ---- test 5 (cont.): RESET in the middle of readout ----
        step(0, 0, 0, 0, 1, 16'h0000);
        $display("seq readout-take cnt=%0d pc=%h", count_a, rd_data_a[55:40]);
        chk("mid.count", 64'(count_a), 64'd3);
        chk("mid.pc", 64'(rd_data_a[55:40]), 64'hC002);
        step(1, 0, 0, 0, 1, 16'h0000);
        $display("seq reset st=%0d cnt=%0d vld=%0b", state_a, count_a, rd_valid_a);
        chk("rst.state", 64'(state_a), 64'd0);
        chk("rst.count", 64'(count_a), 64'd0);
        chk("rst.overflow", 64'(overflow_a), 64'd0);
        chk("rst.rd_valid", 64'(rd_valid_a), 64'd0);
        chk("rst.rd_data_zero", 64'(rd_data_a == '0), 64'd1);

        // Fresh capture after reset, then wait (bounded) for the first entry.
        trig_en = 0;
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 1, 1, 0, 16'hBEEF);
        step(0, 0, 0, 1, 0, 16'hBEF0);
        step(0, 0, 0, 1, 0, 16'hBEF1);
        $display("seq post-reset capture st=%0d cnt=%0d", state_a, count_a);
        chk("again.state", 64'(state_a), 64'd3);
        chk("again.count", 64'(count_a), 64'd3);
        checks++;
        for (int k = 0; k < 8 && !rd_valid_a; k++) step(0, 0, 0, 0, 0, 16'h0000);
        if (!rd_valid_a) begin
            errors++;
            $display("FAIL again.wait_valid: rd_valid still 0 after 8 cycles, required 1");
        end
        chk("again.pc", 64'(rd_data_a[55:40]), 64'hBEEF);

`ifdef TRACE_TIMESTAMP_EN
        // ---- test 6: timestamps at cycles 10 and 13 after reset ----
        step(1, 0, 0, 0, 0, 16'h0000);
        for (int c = 0; c <= 16; c++)
            step(0, c == 1, c == 10, (c == 10) || (c == 13) || (c == 14), c == 16,
                 16'hD000 + 16'(c));
        $display("seq timestamp ts=%0d pc=%h", rd_data_a[EW-1 -: 16], rd_data_a[55:40]);
        chk("ts.second", 64'(rd_data_a[EW-1 -: 16]), 64'd13);
        chk("ts.second_pc", 64'(rd_data_a[55:40]), 64'hD00D);
        step(0, 0, 0, 0, 0, 16'h0000);
        step(1, 0, 0, 0, 0, 16'h0000);
        for (int c = 0; c <= 15; c++)
            step(0, c == 1, c == 10, (c == 10) || (c == 13) || (c == 14), 1'b0,
                 16'hD000 + 16'(c));
        $display("seq timestamp ts=%0d pc=%h", rd_data_a[EW-1 -: 16], rd_data_a[55:40]);
        chk("ts.first", 64'(rd_data_a[EW-1 -: 16]), 64'd10);
        chk("ts.first_pc", 64'(rd_data_a[55:40]), 64'hD00A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
